// File: rtl/sr_rw_control.sv
// Serial write/readback controller for the configuration shift register.
// Shifts a latched word out on din_sr, captures dout_sr into dout, then strobes load_sr.
module sr_rw_control #(
  parameter int unsigned DATA_WIDTH  = 170,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  msb_first,
  input  logic [DIV_WIDTH-1:0]  div_cfg,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  dout_sr,
  output logic                  din_sr,
  output logic                  clk_sr,
  output logic                  load_sr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned LdW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StHi    = 3'd2;
  localparam logic [2:0] StLo    = 3'd3;
  localparam logic [2:0] StTail  = 3'd4;
  localparam logic [2:0] StLoad  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  logic [2:0]            state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rb_q;
  logic                  msb_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  tmr_q;
  logic [CNT_WIDTH-1:0]  bit_cnt_q;
  logic [LdW-1:0]        load_cnt_q;
  logic                  phase_end;

  // Words are held in transmit order: bit 0 is always the next bit on the wire.
  logic [DATA_WIDTH-1:0] din_ord;
  logic [DATA_WIDTH-1:0] rb_ord;

  always_comb begin
    din_ord = '0;
    rb_ord  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      din_ord[i] = msb_first ? din[DATA_WIDTH-1-i] : din[i];
      rb_ord[i]  = msb_q ? rb_q[DATA_WIDTH-1-i] : rb_q[i];
    end
  end

  assign phase_end = (tmr_q == div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      data_q     <= '0;
      rb_q       <= '0;
      msb_q      <= 1'b0;
      div_q      <= '0;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      load_cnt_q <= '0;
      din_sr     <= 1'b0;
      clk_sr     <= 1'b0;
      load_sr    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout       <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q    <= StIdle;
        tmr_q      <= '0;
        bit_cnt_q  <= '0;
        load_cnt_q <= '0;
        din_sr     <= 1'b0;
        clk_sr     <= 1'b0;
        load_sr    <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              data_q    <= din_ord;
              msb_q     <= msb_first;
              div_q     <= div_cfg;
              tmr_q     <= '0;
              bit_cnt_q <= '0;
              din_sr    <= din_ord[0];
              clk_sr    <= 1'b0;
              busy      <= 1'b1;
              state_q   <= StSetup;
            end
          end
          StSetup, StLo: begin
            if (phase_end) begin
              tmr_q   <= '0;
              clk_sr  <= 1'b1;
              state_q <= StHi;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
          StHi: begin
            if (phase_end) begin
              tmr_q  <= '0;
              clk_sr <= 1'b0;
              rb_q   <= {dout_sr, rb_q[DATA_WIDTH-1:1]};
              if (bit_cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                din_sr  <= 1'b0;
                state_q <= StTail;
              end else begin
                din_sr    <= data_q[1];
                data_q    <= {1'b0, data_q[DATA_WIDTH-1:1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                state_q   <= StLo;
              end
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
          StTail: begin
            if (phase_end) begin
              tmr_q      <= '0;
              load_cnt_q <= '0;
              load_sr    <= 1'b1;
              state_q    <= StLoad;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
          StLoad: begin
            if (load_cnt_q == LdW'(LOAD_CYCLES - 1)) begin
              load_sr <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              dout    <= rb_ord;
              state_q <= StDone;
            end else begin
              load_cnt_q <= load_cnt_q + 1'b1;
            end
          end
          StDone: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sr_rw_control.sv
// Directed bench for sr_rw_control: a 4-bit instance for tabled vectors and corner cases,
// and a 170-bit instance for loop-back readback and mid-transfer abort.
module tb_sr_rw_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // 4-bit instance
  logic         st4 = 0, ab4 = 0, msb4 = 0, dsr4;
  logic [7:0]   div4 = '0;
  logic [3:0]   din4 = '0, dout4;
  logic         din_sr4, clk_sr4, load4, busy4, done4;

  // 170-bit instance
  logic         st170 = 0, ab170 = 0, msb170 = 0, dsr170;
  logic [7:0]   div170 = '0;
  logic [169:0] din170 = '0, dout170;
  logic         din_sr170, clk_sr170, load170, busy170, done170;

  sr_rw_control #(.DATA_WIDTH(4), .CNT_WIDTH(3), .DIV_WIDTH(8), .LOAD_CYCLES(2)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .abort(ab4), .msb_first(msb4), .div_cfg(div4),
    .din(din4), .dout_sr(dsr4), .din_sr(din_sr4), .clk_sr(clk_sr4), .load_sr(load4),
    .busy(busy4), .done(done4), .dout(dout4)
  );

  sr_rw_control #(.DATA_WIDTH(170), .CNT_WIDTH(8), .DIV_WIDTH(8), .LOAD_CYCLES(2)) dut170 (
    .clk(clk), .rst(rst), .start(st170), .abort(ab170), .msb_first(msb170), .div_cfg(div170),
    .din(din170), .dout_sr(dsr170), .din_sr(din_sr170), .clk_sr(clk_sr170), .load_sr(load170),
    .busy(busy170), .done(done170), .dout(dout170)
  );

  // SR models: sr[0] leaves first, the departing bit is presented on dout_sr.
  logic [3:0]   sr4, pv4;
  logic         out4, pre4 = 0;
  logic [169:0] sr170, pv170;
  logic         out170, pre170 = 0;

  always @(posedge clk_sr4 or posedge pre4)
    if (pre4) begin sr4 <= pv4; out4 <= 1'b0; end
    else begin sr4 <= {din_sr4, sr4[3:1]}; out4 <= sr4[0]; end
  assign dsr4 = out4;

  always @(posedge clk_sr170 or posedge pre170)
    if (pre170) begin sr170 <= pv170; out170 <= 1'b0; end
    else begin sr170 <= {din_sr170, sr170[169:1]}; out170 <= sr170[0]; end
  assign dsr170 = out170;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [169:0] rev170(input logic [169:0] v);
    logic [169:0] r;
    for (int i = 0; i < 170; i++) r[i] = v[169-i];
    return r;
  endfunction

  // Results of the last observed transfer
  int         r_rises, r_busy, r_load, r_done, r_gap;
  logic [3:0] r_seq;
  logic       r_to;

  // Caller is just after a negedge. Stops at the negedge where done is seen.
  task automatic xfer(input bit sel, input bit do_start, input bit hold, input int mut_cyc,
                      input int budget);
    logic pc, cs, ds;
    int   last;
    r_rises = 0; r_busy = 0; r_load = 0; r_done = 0; r_gap = 1000; r_seq = '0; r_to = 1;
    last = 1; pc = 1'b0;
    if (do_start) begin
      if (sel) st170 = 1'b1; else st4 = 1'b1;
    end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (!hold) begin st4 = 1'b0; st170 = 1'b0; end
      if (c == mut_cyc) begin din4 = ~din4; div4 = 8'd0; msb4 = ~msb4; end
      cs = sel ? clk_sr170 : clk_sr4;
      ds = sel ? din_sr170 : din_sr4;
      if (cs !== pc) begin
        if (c - last < r_gap) r_gap = c - last;
        last = c;
      end
      if (cs && !pc) begin
        if (!sel && r_rises < 4) r_seq[r_rises] = ds;
        r_rises++;
      end
      pc = cs;
      if (sel ? busy170 : busy4) r_busy++;
      if (sel ? load170 : load4) r_load++;
      if (sel ? done170 : done4) begin
        r_done++;
        r_to = 1'b0;
        break;
      end
    end
    chk("xfer completes in budget", r_to, 1'b0);
  endtask

  task automatic preload4(input logic [3:0] v);
    pv4 = v; pre4 = 1'b1; #1; pre4 = 1'b0;
  endtask

  typedef struct {
    logic [3:0] din;
    logic       msb;
    logic [7:0] div;
    logic [3:0] pre;
    logic [3:0] seq;   // seq[k] = k-th bit sent
    logic [3:0] dout;
    int         busy;
  } vec_t;

  vec_t vt[4];
  logic [169:0] a170, b170, p170;
  int           rises, lcnt, dcnt, bcnt;
  logic         pc;

  initial begin
    vt[0] = '{din: 4'b1011, msb: 1'b0, div: 8'd0, pre: 4'b0110, seq: 4'b1011, dout: 4'b0110, busy: 11};
    vt[1] = '{din: 4'b1011, msb: 1'b1, div: 8'd0, pre: 4'b0011, seq: 4'b1101, dout: 4'b1100, busy: 11};
    vt[2] = '{din: 4'b0100, msb: 1'b0, div: 8'd2, pre: 4'b1001, seq: 4'b0100, dout: 4'b1001, busy: 29};
    vt[3] = '{din: 4'b1110, msb: 1'b1, div: 8'd1, pre: 4'b0101, seq: 4'b0111, dout: 4'b1010, busy: 20};

    // Reset values
    #12;
    chk("rst din_sr", {din_sr4, din_sr170}, 2'b00);
    chk("rst clk_sr", {clk_sr4, clk_sr170}, 2'b00);
    chk("rst load_sr", {load4, load170}, 2'b00);
    chk("rst busy", {busy4, busy170}, 2'b00);
    chk("rst done", {done4, done170}, 2'b00);
    chk("rst dout4", dout4, 4'h0);
    chk("rst dout170", dout170, 170'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Tabled transfers on the 4-bit instance
    for (int i = 0; i < 4; i++) begin
      din4 = vt[i].din; msb4 = vt[i].msb; div4 = vt[i].div;
      preload4(vt[i].pre);
      xfer(1'b0, 1'b1, 1'b0, 0, 400);
      chk($sformatf("v%0d clk_sr rises", i), r_rises, 4);
      chk($sformatf("v%0d din_sr bits", i), r_seq, vt[i].seq);
      chk($sformatf("v%0d busy cycles", i), r_busy, vt[i].busy);
      chk($sformatf("v%0d load_sr cycles", i), r_load, 2);
      chk($sformatf("v%0d done count", i), r_done, 1);
      chk($sformatf("v%0d dout", i), dout4, vt[i].dout);
      chk($sformatf("v%0d sr contents", i), sr4, vt[i].seq);
      chk($sformatf("v%0d min clk_sr gap", i), r_gap, int'(vt[i].div) + 1);
      @(negedge clk);
      chk($sformatf("v%0d done is one pulse", i), {done4, busy4}, 2'b00);
    end

    // Inputs changed mid-transfer: result must follow the latched vt[3] values
    din4 = vt[3].din; msb4 = vt[3].msb; div4 = vt[3].div;
    preload4(vt[3].pre);
    xfer(1'b0, 1'b1, 1'b0, 3, 400);
    chk("mid-change din_sr bits", r_seq, vt[3].seq);
    chk("mid-change busy cycles", r_busy, vt[3].busy);
    chk("mid-change min gap", r_gap, 2);
    chk("mid-change dout", dout4, vt[3].dout);
    @(negedge clk);

    // start held through a whole transfer and DONE
    din4 = vt[0].din; msb4 = vt[0].msb; div4 = vt[0].div;
    preload4(vt[0].pre);
    xfer(1'b0, 1'b1, 1'b1, 0, 400);
    chk("held start done count", r_done, 1);
    chk("held start busy cycles", r_busy, 11);
    chk("held start dout", dout4, 4'b0110);
    @(negedge clk);
    chk("start ignored in DONE", busy4, 1'b0);
    @(negedge clk);
    chk("restart from IDLE", busy4, 1'b1);
    st4 = 1'b0;
    xfer(1'b0, 1'b0, 1'b0, 0, 400);
    chk("second run rises", r_rises, 4);
    chk("second run busy remaining", r_busy, 10);
    chk("second run readback", dout4, 4'b1011);
    @(negedge clk);

    // abort with start in IDLE: nothing happens
    st4 = 1'b1; ab4 = 1'b1;
    @(negedge clk);
    chk("abort blocks start in IDLE", busy4, 1'b0);
    st4 = 1'b0; ab4 = 1'b0;
    @(negedge clk);
    chk("still idle after abort", busy4, 1'b0);

    // 170-bit loop-back, msb first, H=4
    for (int i = 0; i < 170; i++) begin
      a170[i] = 1'($urandom_range(0, 1));
      b170[i] = 1'($urandom_range(0, 1));
      p170[i] = 1'($urandom_range(0, 1));
    end
    din170 = a170; msb170 = 1'b1; div170 = 8'd3;
    pv170 = p170; pre170 = 1'b1; #1; pre170 = 1'b0;
    xfer(1'b1, 1'b1, 1'b0, 0, 5000);
    chk("n170 rises", r_rises, 170);
    chk("n170 half period", r_gap, 4);
    chk("n170 busy cycles", r_busy, 1366);
    chk("n170 load cycles", r_load, 2);
    chk("n170 readback preload", dout170, rev170(p170));
    chk("n170 sr contents", sr170, rev170(a170));
    @(negedge clk);
    din170 = b170;
    xfer(1'b1, 1'b1, 1'b0, 0, 5000);
    chk("n170 second readback", dout170, a170);
    chk("n170 second sr contents", sr170, rev170(b170));
    @(negedge clk);

    // abort at 50th clk_sr rise
    div170 = 8'd0; msb170 = 1'b0; st170 = 1'b1;
    rises = 0; pc = 1'b0;
    for (int c = 0; c < 2000 && rises < 50; c++) begin
      @(negedge clk);
      st170 = 1'b0;
      if (clk_sr170 && !pc) rises++;
      pc = clk_sr170;
    end
    chk("reached 50th rise", rises, 50);
    ab170 = 1'b1;
    @(negedge clk);
    ab170 = 1'b0;
    chk("abort outputs", {busy170, clk_sr170, din_sr170, load170, done170}, 5'b0);
    lcnt = 0; dcnt = 0; bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (load170) lcnt++;
      if (done170) dcnt++;
      if (busy170) bcnt++;
    end
    chk("abort no load/done/busy", {lcnt, dcnt, bcnt}, 96'h0);
    chk("abort dout unchanged", dout170, a170);

    // rst during LOAD
    din4 = vt[0].din; msb4 = vt[0].msb; div4 = vt[0].div;
    preload4(vt[0].pre);
    st4 = 1'b1;
    lcnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      st4 = 1'b0;
      if (load4) begin lcnt = 1; break; end
    end
    chk("reached LOAD", lcnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst outputs", {din_sr4, clk_sr4, load4, busy4, done4}, 5'b0);
    chk("async rst dout", dout4, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    preload4(vt[0].pre);
    xfer(1'b0, 1'b1, 1'b0, 0, 400);
    chk("post-rst din_sr bits", r_seq, vt[0].seq);
    chk("post-rst busy cycles", r_busy, 11);
    chk("post-rst dout", dout4, vt[0].dout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
